fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_arbiter_pkg.sv | 19 +
 rtl/fb_rd_tag_pipe.sv | 32 +++
 rtl/fb_arbiter.sv | 122 ++++++++++++
 tb/tb_fb_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fb_arbiter_pkg.sv
// Shared definitions for the frame-buffer arbiter: grant-state encoding and
// read-owner tags carried through the in-flight pipeline.
package fb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT_PIX  = 2'd1,
        GRANT_HOST = 2'd2,
        FORCE_HOST = 2'd3
    } grant_state_t;

    localparam logic TAG_PIX  = 1'b0;
    localparam logic TAG_HOST = 1'b1;

    function automatic logic is_host(input grant_state_t s);
        return (s == GRANT_HOST) || (s == FORCE_HOST);
    endfunction

endpackage

// File: rtl/fb_rd_tag_pipe.sv
// Two-stage delay line that tracks which requester owns each in-flight read,
// aligned with the SRAM read data two cycles after the transfer.
module fb_rd_tag_pipe
    import fb_arbiter_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic issue_valid,
    input  logic issue_owner,
    output logic ret_valid,
    output logic ret_owner
);

    logic [1:0] valid_q;
    logic [1:0] owner_q;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the value from before the edge, not its neighbour's new value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= 2'b00;
            owner_q <= {2{TAG_PIX}};
        end else begin
            valid_q <= {valid_q[0], issue_valid};
            owner_q <= {owner_q[0], issue_owner};
        end
    end

    assign ret_valid = valid_q[1];
    assign ret_owner = owner_q[1];

endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer SRAM arbiter between scanout and host, with VBLANK-dependent
// priority, a host starvation override, and registered SRAM command outputs.
module fb_arbiter
    import fb_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              VBLANK,
    input  logic              PIX_REQ,
    input  logic [ADDR_W-1:0] PIX_ADDR,
    output logic              PIX_ACK,
    output logic              PIX_VALID,
    output logic [DATA_W-1:0] PIX_DATA,
    input  logic              HOST_REQ,
    input  logic              HOST_WE,
    input  logic [ADDR_W-1:0] HOST_ADDR,
    input  logic [DATA_W-1:0] HOST_WDATA,
    output logic              HOST_ACK,
    output logic              HOST_VALID,
    output logic [DATA_W-1:0] HOST_RDATA,
    output logic              MEM_EN,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    grant_state_t     state_q, state_d;
    logic [CNT_W-1:0] starve_cnt;
    logic             starved;
    logic             ret_valid, ret_owner;
    logic [DATA_W-1:0] pix_data_q, host_rdata_q;

    assign starved = HOST_REQ && (starve_cnt == CNT_MAX);

    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = IDLE;
        if (RST) begin
            state_d = IDLE;
        end else if (starved) begin
            state_d = FORCE_HOST;
        end else if (VBLANK) begin
            if (HOST_REQ)     state_d = GRANT_HOST;
            else if (PIX_REQ) state_d = GRANT_PIX;
        end else begin
            if (PIX_REQ)       state_d = GRANT_PIX;
            else if (HOST_REQ) state_d = GRANT_HOST;
        end
    end

    always_comb begin
        PIX_ACK  = (state_d == GRANT_PIX);
        HOST_ACK = is_host(state_d);
    end

    // Cleared whenever the host is served or stops asking.
    always_ff @(posedge CLK) begin
        if (RST || !HOST_REQ || HOST_ACK) starve_cnt <= '0;
        else if (starve_cnt != CNT_MAX)   starve_cnt <= starve_cnt + 1'b1;
    end

    // The registered winner of the previous cycle is the SRAM enable.
    assign MEM_EN = (state_q != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
        end else if (PIX_ACK) begin
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= PIX_ADDR;
        end else if (HOST_ACK) begin
            MEM_WE    <= HOST_WE;
            MEM_ADDR  <= HOST_ADDR;
            MEM_WDATA <= HOST_WDATA;
        end else begin
            MEM_WE    <= 1'b0;
        end
    end

    fb_rd_tag_pipe u_tag_pipe (
        .CLK         (CLK),
        .RST         (RST),
        .issue_valid (PIX_ACK || (HOST_ACK && !HOST_WE)),
        .issue_owner (HOST_ACK ? TAG_HOST : TAG_PIX),
        .ret_valid   (ret_valid),
        .ret_owner   (ret_owner)
    );

    assign PIX_VALID  = ret_valid && (ret_owner == TAG_PIX);
    assign HOST_VALID = ret_valid && (ret_owner == TAG_HOST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            pix_data_q   <= '0;
            host_rdata_q <= '0;
        end else begin
            if (PIX_VALID)  pix_data_q   <= MEM_RDATA;
            if (HOST_VALID) host_rdata_q <= MEM_RDATA;
        end
    end

    // Read data passes straight through on its VALID cycle and holds after.
    assign PIX_DATA   = PIX_VALID  ? MEM_RDATA : pix_data_q;
    assign HOST_RDATA = HOST_VALID ? MEM_RDATA : host_rdata_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural SRAM and a read scoreboard
// that expects owner, data and arrival cycle for every accepted read.
module tb_fb_arbiter;
    import fb_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        vblank;
    logic        pix_req, pix_ack, pix_valid;
    logic [18:0] pix_addr;
    logic [7:0]  pix_data;
    logic        host_req, host_we, host_ack, host_valid;
    logic [18:0] host_addr;
    logic [7:0]  host_wdata, host_rdata;
    logic        mem_en, mem_we;
    logic [18:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int pix_vcnt = 0;
    int host_vcnt = 0;

    typedef struct {
        logic       owner;
        logic [7:0] data;
        int         due;
    } sb_t;
    sb_t sb[$];

    logic [7:0] sram      [bit [18:0]];
    logic [7:0] model_mem [bit [18:0]];

    fb_arbiter dut (
        .CLK        (clk),
        .RST        (rst),
        .VBLANK     (vblank),
        .PIX_REQ    (pix_req),
        .PIX_ADDR   (pix_addr),
        .PIX_ACK    (pix_ack),
        .PIX_VALID  (pix_valid),
        .PIX_DATA   (pix_data),
        .HOST_REQ   (host_req),
        .HOST_WE    (host_we),
        .HOST_ADDR  (host_addr),
        .HOST_WDATA (host_wdata),
        .HOST_ACK   (host_ack),
        .HOST_VALID (host_valid),
        .HOST_RDATA (host_rdata),
        .MEM_EN     (mem_en),
        .MEM_WE     (mem_we),
        .MEM_ADDR   (mem_addr),
        .MEM_WDATA  (mem_wdata),
        .MEM_RDATA  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Unwritten words hold an address-derived pattern.
    function automatic logic [7:0] fill(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] model_rd(input logic [18:0] a);
        return model_mem.exists(a) ? model_mem[a] : fill(a);
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] = mem_wdata;
            else        mem_rdata <= sram.exists(mem_addr) ? sram[mem_addr] : fill(mem_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pops on VALID, pushes on accepted reads, flushes on reset.
    always @(negedge clk) begin
        sb_t e;
        check("ack_exclusive", {31'd0, pix_ack & host_ack}, 32'd0);
        check("ack_without_req", {31'd0, (pix_ack & ~pix_req) | (host_ack & ~host_req)}, 32'd0);
        if (pix_valid || host_valid) begin
            if (pix_valid)  pix_vcnt++;
            if (host_valid) host_vcnt++;
            check("valid_exclusive", {31'd0, pix_valid & host_valid}, 32'd0);
            check("sb_pending_on_valid", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_owner", {31'd0, host_valid}, {31'd0, e.owner});
                check("sb_data", {24'd0, host_valid ? host_rdata : pix_data}, {24'd0, e.data});
                check("sb_latency", cyc, e.due);
            end
        end
        if (rst) begin
            sb.delete();
        end else begin
            if (pix_req && pix_ack)
                sb.push_back('{TAG_PIX, model_rd(pix_addr), cyc + 2});
            if (host_req && host_ack) begin
                if (host_we) model_mem[host_addr] = host_wdata;
                else         sb.push_back('{TAG_HOST, model_rd(host_addr), cyc + 2});
            end
        end
    end

    initial begin
        int p0, h0;
        rst = 1'b1; vblank = 1'b0;
        pix_req = 1'b0; pix_addr = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        repeat (2) @(posedge clk);
        #1;

        // Requests during reset must not be granted.
        pix_req = 1'b1; pix_addr = 19'h10;
        host_req = 1'b1; host_addr = 19'h20;
        @(negedge clk);
        check("rst_pix_ack", {31'd0, pix_ack}, 32'd0);
        check("rst_host_ack", {31'd0, host_ack}, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {13'd0, mem_addr}, 32'd0);
        check("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
        check("rst_host_valid", {31'd0, host_valid}, 32'd0);
        check("rst_pix_data", {24'd0, pix_data}, 32'd0);
        check("rst_host_rdata", {24'd0, host_rdata}, 32'd0);
        next_cycle();
        rst = 1'b0;

        // Active video, both requesting: pixel wins until the 17th cycle.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            check("starve_pix_ack", {31'd0, pix_ack}, {31'd0, i != 16});
            check("starve_host_ack", {31'd0, host_ack}, {31'd0, i == 16});
            if (i == 4)  check("starve_cnt_4", 32'(dut.starve_cnt), 32'd4);
            if (i == 16) check("starve_cnt_max", 32'(dut.starve_cnt), 32'd16);
            next_cycle();
        end
        pix_req = 1'b0; host_req = 1'b0;
        repeat (4) next_cycle();

        // Blanking: host write wins, then pixel reads the written word back.
        vblank = 1'b1;
        host_req = 1'b1; host_we = 1'b1; host_addr = 19'h100; host_wdata = 8'h5A;
        pix_req = 1'b1; pix_addr = 19'h100;
        @(negedge clk);
        check("vb_host_ack", {31'd0, host_ack}, 32'd1);
        check("vb_pix_ack", {31'd0, pix_ack}, 32'd0);
        next_cycle();
        host_req = 1'b0; host_we = 1'b0;
        @(negedge clk);
        check("vb_pix_ack2", {31'd0, pix_ack}, 32'd1);
        check("wr_mem_en", {31'd0, mem_en}, 32'd1);
        check("wr_mem_we", {31'd0, mem_we}, 32'd1);
        check("wr_mem_addr", {13'd0, mem_addr}, 32'h100);
        check("wr_mem_wdata", {24'd0, mem_wdata}, 32'h5A);
        next_cycle();
        pix_req = 1'b0;
        @(negedge clk);
        check("rd_mem_en", {31'd0, mem_en}, 32'd1);
        check("rd_mem_we", {31'd0, mem_we}, 32'd0);
        check("rd_mem_addr", {13'd0, mem_addr}, 32'h100);
        check("rd_early_valid", {31'd0, pix_valid}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("rd_pix_valid", {31'd0, pix_valid}, 32'd1);
        check("rd_pix_data", {24'd0, pix_data}, 32'h5A);
        next_cycle();
        @(negedge clk);
        check("hold_pix_valid", {31'd0, pix_valid}, 32'd0);
        check("hold_pix_data", {24'd0, pix_data}, 32'h5A);
        check("idle_mem_en", {31'd0, mem_en}, 32'd0);
        next_cycle();

        // Alternating back-to-back reads from both requesters.
        vblank = 1'b0;
        p0 = pix_vcnt; h0 = host_vcnt;
        for (int i = 0; i < 6; i++) begin
            pix_req  = (i % 2 == 0);
            host_req = (i % 2 == 1);
            host_we  = 1'b0;
            pix_addr  = 19'h200 + 19'(i);
            host_addr = 19'h300 + 19'(i);
            @(negedge clk);
            check("alt_pix_ack", {31'd0, pix_ack}, {31'd0, i % 2 == 0});
            check("alt_host_ack", {31'd0, host_ack}, {31'd0, i % 2 == 1});
            next_cycle();
        end
        pix_req = 1'b0; host_req = 1'b0;
        repeat (4) next_cycle();
        check("alt_pix_valids", pix_vcnt - p0, 32'd3);
        check("alt_host_valids", host_vcnt - h0, 32'd3);

        // Reset right after an accepted read drops that read.
        p0 = pix_vcnt;
        pix_req = 1'b1; pix_addr = 19'h100;
        @(negedge clk);
        check("rr_pix_ack", {31'd0, pix_ack}, 32'd1);
        next_cycle();
        pix_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rr_valid_n1", {31'd0, pix_valid}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("rr_pix_valid", {31'd0, pix_valid}, 32'd0);
        check("rr_host_valid", {31'd0, host_valid}, 32'd0);
        check("rr_mem_en", {31'd0, mem_en}, 32'd0);
        check("rr_mem_we", {31'd0, mem_we}, 32'd0);
        check("rr_mem_addr", {13'd0, mem_addr}, 32'd0);
        check("rr_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rr_pix_data", {24'd0, pix_data}, 32'd0);
        check("rr_host_rdata", {24'd0, host_rdata}, 32'd0);
        next_cycle();
        rst = 1'b0;
        repeat (3) next_cycle();
        check("rr_no_valid", pix_vcnt - p0, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
